// File: rtl/b16fp_pkg.sv
// Shared definitions for the bfloat16 dot-product sequencer.
package b16fp_pkg;

  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/b16fp_dot_seq.sv
// Dot-product sequencer: clears the external bf16 MAC, streams N operand
// pairs into it, waits out its pipeline and returns the sum via valid/ready.
module b16fp_dot_seq
  import b16fp_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1,
  parameter int CLR_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [BF16_W-1:0] op_a,
  input  logic [BF16_W-1:0] op_b,
  output logic              mac_rst,
  output logic              mac_valid,
  output logic [BF16_W-1:0] mac_oprA,
  output logic [BF16_W-1:0] mac_oprB,
  input  logic [BF16_W-1:0] mac_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BF16_W-1:0] res_data,
  output logic              busy
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int DRN_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  seq_state_e        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [CLR_W-1:0]  clr_q;
  logic [DRN_W-1:0]  drn_q;
  logic              clr_act_q;
  logic              mac_valid_q;
  logic [BF16_W-1:0] opra_q;
  logic [BF16_W-1:0] oprb_q;
  logic              res_valid_q;
  logic [BF16_W-1:0] res_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      clr_q       <= '0;
      drn_q       <= '0;
      clr_act_q   <= 1'b0;
      mac_valid_q <= 1'b0;
      opra_q      <= BF16_ZERO;
      oprb_q      <= BF16_ZERO;
      res_valid_q <= 1'b0;
      res_data_q  <= BF16_ZERO;
    end else begin
      mac_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q <= cmd_len;
            if (cmd_len == '0) begin
              res_data_q  <= BF16_ZERO;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              clr_q     <= CLR_W'(CLR_CYC - 1);
              clr_act_q <= 1'b1;
              state_q   <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (clr_q == '0) begin
            rem_q     <= len_q;
            clr_act_q <= 1'b0;
            state_q   <= ST_FEED;
          end else begin
            clr_q <= clr_q - 1'b1;
          end
        end
        ST_FEED: begin
          if (op_valid) begin
            opra_q      <= op_a;
            oprb_q      <= op_b;
            mac_valid_q <= 1'b1;
            rem_q       <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              drn_q   <= DRN_W'(MAC_LAT);
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The latency count starts only once the MAC has sampled the final
          // operand pair, i.e. after the last mac_valid cycle has passed.
          if (!mac_valid_q) begin
            if (drn_q == '0) begin
              res_data_q  <= mac_result;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              drn_q <= drn_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (res_ready && res_valid_q) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign op_ready  = (state_q == ST_FEED);
  assign busy      = (state_q != ST_IDLE);
  assign mac_rst   = rst | clr_act_q;
  assign mac_valid = mac_valid_q;
  assign mac_oprA  = opra_q;
  assign mac_oprB  = oprb_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_b16fp_dot_seq.sv
// Self-checking bench for b16fp_dot_seq with a behavioural MAC beside it.
module tb_b16fp_dot_seq;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;
  localparam int CLR_CYC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a, op_b;
  logic             mac_rst, mac_valid;
  logic [15:0]      mac_oprA, mac_oprB, mac_result;
  logic             res_valid, res_ready;
  logic [15:0]      res_data;
  logic             busy;

  b16fp_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_rst(mac_rst), .mac_valid(mac_valid), .mac_oprA(mac_oprA), .mac_oprB(mac_oprB),
    .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int mr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mac_valid) mv_cnt <= mv_cnt + 1;
    if (mac_rst)   mr_cnt <= mr_cnt + 1;
  end

  function automatic real bf2r(input logic [15:0] h);
    logic [63:0] d;
    if (h[14:0] == 15'd0) return 0.0;
    d = {h[15], {3'b000, h[14:7]} + 11'd896, h[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:45]};
  endfunction

  // Behavioural MAC: accumulates on valid, result register one cycle behind.
  real acc = 0.0;
  logic [15:0] mac_res_q = 16'h0000;
  always @(posedge clk) begin
    if (mac_rst) begin
      acc       <= 0.0;
      mac_res_q <= 16'h0000;
    end else begin
      if (mac_valid) acc <= acc + bf2r(mac_oprA) * bf2r(mac_oprB);
      mac_res_q <= r2bf(acc);
    end
  end
  assign mac_result = mac_res_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic [15:0] va[256];
  logic [15:0] vb[256];

  task automatic send_cmd(input int len, output int acc_cyc);
    int t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic do_dot(input int len, input int gap_after, input int gap_len,
                        input int hold, input logic [15:0] exp_data, input int exp_lat);
    int acc_cyc, i, guard, gleft, t, mv0, mr0;
    logic beat;
    mv0 = mv_cnt;
    mr0 = mr_cnt;
    send_cmd(len, acc_cyc);
    i = 0; guard = 0; gleft = gap_len;
    while (i < len && guard < len + gap_len + 50) begin
      if (i == gap_after && gleft > 0) begin
        op_valid = 1'b0;
        gleft--;
      end else begin
        op_valid = 1'b1;
        op_a = va[i];
        op_b = vb[i];
      end
      beat = op_valid && op_ready;
      @(negedge clk);
      if (beat) i++;
      guard++;
    end
    op_valid = 1'b0;
    check("beats_accepted", 32'(i), 32'(len));
    t = 0;
    while (!res_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_rise", 32'(res_valid), 32'd1);
    check("res_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    check("res_data", 32'(res_data), 32'(exp_data));
    for (int k = 0; k < hold; k++) begin
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(7);
      @(negedge clk);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", 32'(res_data), 32'(exp_data));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_res_valid", 32'(res_valid), 32'd0);
    check("release_idle", 32'(cmd_ready), 32'd1);
    check("mac_valid_pulses", 32'(mv_cnt - mv0), 32'(len));
    check("mac_rst_cycles", 32'(mr_cnt - mr0), (len == 0) ? 32'd0 : 32'(CLR_CYC));
  endtask

  typedef struct {
    int len; int gap_after; int gap_len; int hold;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [15:0] exp_data;
    int lat;
  } vec_t;

  function automatic vec_t mk(input int len, input int ga, input int gl, input int hold,
                              input logic [15:0] a0, a1, a2, b0, b1, b2,
                              input logic [15:0] ex, input int lat);
    vec_t v;
    v.len = len; v.gap_after = ga; v.gap_len = gl; v.hold = hold;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    v.exp_data = ex; v.lat = lat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [15:0] opset[8];
    int ac, rv_seen;
    real sum;

    tbl[0] = mk(3, 0, 0, 0, 16'h3F80, 16'h4000, 16'h4040, 16'h4000, 16'h4000, 16'h4000, 16'h4140, 8);
    tbl[1] = mk(3, 1, 2, 0, 16'h3F80, 16'h4000, 16'h4040, 16'h4000, 16'h4000, 16'h4000, 16'h4140, 10);
    tbl[2] = mk(1, 0, 0, 0, 16'h3F00, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h3F80, 6);
    tbl[3] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    tbl[4] = mk(3, 0, 0, 5, 16'h3F80, 16'h4000, 16'h4040, 16'h4000, 16'h4000, 16'h4000, 16'h4140, 8);
    opset = '{16'h3F80, 16'h4000, 16'h4040, 16'h3F00, 16'hBF80, 16'h4080, 16'hC000, 16'h0000};

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mac_rst", 32'(mac_rst), 32'd1);
    check("rst_mac_valid", 32'(mac_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_oprA", 32'(mac_oprA), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_mac_rst", 32'(mac_rst), 32'd0);

    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 3; j++) begin
        va[j] = tbl[n].a[j];
        vb[j] = tbl[n].b[j];
      end
      do_dot(tbl[n].len, tbl[n].gap_after, tbl[n].gap_len, tbl[n].hold,
             tbl[n].exp_data, tbl[n].lat);
    end

    // Reset one cycle after the first of three beats.
    va[0] = 16'h3F80; vb[0] = 16'h4000;
    send_cmd(3, ac);
    begin
      int t = 0;
      op_valid = 1'b1; op_a = va[0]; op_b = vb[0];
      while (!op_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("midfeed_op_ready", 32'(op_ready), 32'd1);
      @(negedge clk);
    end
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mac_rst", 32'(mac_rst), 32'd1);
    check("midrst_mac_valid", 32'(mac_valid), 32'd0);
    check("midrst_oprA", 32'(mac_oprA), 32'd0);
    check("midrst_oprB", 32'(mac_oprB), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("midrst_no_result", 32'(rv_seen), 32'd0);
    va[0] = 16'h3F80; vb[0] = 16'h3F80;
    do_dot(1, 0, 0, 0, 16'h3F80, 6);

    // Maximum vector length.
    for (int j = 0; j < 255; j++) begin
      va[j] = 16'h3F80;
      vb[j] = 16'h3F80;
    end
    do_dot(255, 0, 0, 0, 16'h437F, CLR_CYC + 255 + MAC_LAT + 2);

    for (int r = 0; r < 20; r++) begin
      int len, ga, gl, hold;
      len  = int'($urandom_range(6, 0));
      ga   = (len > 1) ? int'($urandom_range(len - 1, 1)) : 0;
      gl   = (len > 1) ? int'($urandom_range(3, 0)) : 0;
      hold = int'($urandom_range(2, 0));
      sum  = 0.0;
      for (int j = 0; j < len; j++) begin
        va[j] = opset[$urandom_range(7, 0)];
        vb[j] = opset[$urandom_range(7, 0)];
        sum   = sum + bf2r(va[j]) * bf2r(vb[j]);
      end
      do_dot(len, ga, gl, hold, r2bf(sum),
             (len == 0) ? 0 : CLR_CYC + len + gl + MAC_LAT + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
